missionary_cannibal_ctrl: RTL
=============================

Name: missionary_cannibal_ctrl

Overview:
Sequential controller that holds the puzzle state and drives the combinational next-state stage `missionary_cannibal` that sits directly downstream.
- Registers missionary/cannibal counts and boat direction, and presents them as that stage's inputs.
- Validates each proposed next state and commits it one crossing per step.
- Counts crossings and flags completion or error.
- Top-level puzzle sequencer for the board demo.

Parameters:
STEP_LIMIT, 15, max crossings before ERR; must be 1..15 (fits step_count)
HIST_DEPTH, 16, undo history entries (used only with MC_UNDO_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  pulse; (re)initialise puzzle and enter RUN
step_en  input  1  commit one crossing this cycle
undo  input  1  revert last crossing (MC_UNDO_EN only)
missionary_next  input  2  proposed missionaries on start bank, from next-state stage
cannibal_next  input  2  proposed cannibals on start bank, from next-state stage
missionary_curr  output  2  registered missionaries on start bank
cannibal_curr  output  2  registered cannibals on start bank
direction  output  1  1 = boat at start bank (next crossing outbound), 0 = boat at far bank
step_count  output  4  crossings committed
busy  output  1  high in RUN
done  output  1  high in DONE
error  output  1  high in ERR

Behaviour:
Reset values:
- State IDLE, missionary_curr=3, cannibal_curr=3, direction=1, step_count=0.
- busy=0, done=0, error=0.
- All outputs are registered.
- Reset is honoured mid-operation; the history stack is cleared.

direction:
- Always equals ~step_count[0]. No separate state.

States:
- IDLE -> RUN on start. Loads (3,3), step_count=0.
- RUN, step_en=1: check (m,c)=(missionary_next,cannibal_next) against (M,C)=current:
  - Safe: (m==0 or m>=c) and (m==3 or 3-m>=3-c).
  - Move: direction=1 requires m<=M, c<=C and 1<=(M-m)+(C-c)<=2. direction=0 requires m>=M, c>=C and 1<=(m-M)+(c-C)<=2.
  - Pass: commit (m,c) next edge and increment step_count. If committed (m,c)==(0,0) -> DONE, else stay in RUN.
  - Fail, or step_count==STEP_LIMIT -> ERR. Registered state is not updated.
- RUN, step_en=0: hold.
- DONE / ERR: hold all values. start -> reinitialise as from IDLE (RUN, (3,3), count 0).

Precedence and boundaries:
- start in RUN is ignored.
- start and step_en in the same IDLE/DONE/ERR cycle: start only.
- step_en outside RUN is ignored.
- Latency: one cycle from step_en sample to updated outputs. done/error assert on that same edge.
- step_count never wraps. Limit check precedes increment.

Optional Feature:
MC_UNDO_EN
- Defined:
  - HIST_DEPTH x 4-bit stack of pre-commit (M,C), pushed on every commit.
  - In RUN or DONE with step_en=0, undo=1 and step_count>0: pop into (M,C), decrement step_count (direction follows), state -> RUN.
  - undo at step_count==0 is ignored.
  - step_en has priority over undo.
  - Stack pointer = step_count.
  - start clears the stack.
  - Undo in ERR is ignored.
- Not defined: undo port present but ignored; no stack storage.

Test Plan:
1. Reset, start, step_en held high, next-state stage in loop. Expected (M,C,dir) trace: (3,3,1),(3,1,0),(3,2,1),(3,0,0),(3,1,1),(1,1,0),(2,2,1),(0,2,0),(0,3,1),(0,1,0),(0,2,1),(0,0,0). Then done=1, step_count=11, busy=0.
2. Same run with step_en toggled every other cycle -> identical trace; each state held during gap cycles; done after 11 commits.
3. Error injection at (3,3,1): force next=(1,3) -> error=1, outputs stay (3,3,1), count 0. Force next=(3,3) (no move) after restart -> error=1. Start -> RUN, (3,3,1), error=0.
4. Reset asserted asynchronously mid-run at step_count=5 -> outputs immediately (3,3,1), count 0, busy=0. Start -> run completes normally.
5. STEP_LIMIT=3 with legal oscillation (3,3)->(3,1)->(3,2)->(3,1) forced -> fourth step_en gives error=1, step_count=3.
6. MC_UNDO_EN: run to (0,0) DONE. Undo -> (0,2,1), count 10, RUN. Undo -> (0,1,0), count 9. step_en -> (0,2), count 10. Undo at count 0 -> no change.

Source files
------------

// File: rtl/missionary_cannibal_ctrl.sv
// missionary_cannibal_ctrl: registered puzzle state for the missionaries-and-cannibals demo.
// Holds (M,C) on the start bank, validates the proposal from the downstream next-state stage,
// commits one crossing per step and flags completion or error.
// Optional build macro MC_UNDO_EN adds a HIST_DEPTH-entry undo stack indexed by step_count.
module missionary_cannibal_ctrl #(
    parameter int unsigned STEP_LIMIT = 15,
    parameter int unsigned HIST_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       step_en,
    input  logic       undo,
    input  logic [1:0] missionary_next,
    input  logic [1:0] cannibal_next,
    output logic [1:0] missionary_curr,
    output logic [1:0] cannibal_curr,
    output logic       direction,
    output logic [3:0] step_count,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [1:0] {StIdle, StRun, StDone, StErr} state_e;

    state_e     state_q, state_d;
    logic [1:0] m_q, m_d, c_q, c_d;
    logic [3:0] count_q, count_d;
    logic       busy_q, done_q, error_q;
    logic       push;

    // Proposal legality, widened to 3 bits so the bank differences never underflow.
    logic [2:0] m_n, c_n, m_c, c_c, delta;
    logic       safe, dir_ok, move_ok, at_limit;

    // Check safety of the proposed bank counts and that it is a real 1-2 person crossing.
    always_comb begin
        m_n = {1'b0, missionary_next};
        c_n = {1'b0, cannibal_next};
        m_c = {1'b0, m_q};
        c_c = {1'b0, c_q};
        safe = ((m_n == 3'd0) || (m_n >= c_n)) &&
               ((m_n == 3'd3) || ((3'd3 - m_n) >= (3'd3 - c_n)));
        if (direction) begin
            dir_ok = (m_n <= m_c) && (c_n <= c_c);
            delta  = (m_c - m_n) + (c_c - c_n);
        end else begin
            dir_ok = (m_n >= m_c) && (c_n >= c_c);
            delta  = (m_n - m_c) + (c_n - c_c);
        end
        move_ok  = dir_ok && (delta >= 3'd1) && (delta <= 3'd2);
        at_limit = (count_q == 4'(STEP_LIMIT));
    end

`ifdef MC_UNDO_EN
    localparam int unsigned HistAw = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

    logic [3:0] hist_q [HIST_DEPTH];
    logic [3:0] hist_top;
    logic       pop_ok;

    // Stack pointer is step_count itself, so the top entry sits at step_count-1.
    assign hist_top = hist_q[HistAw'(count_q - 4'd1)];
    assign pop_ok   = !step_en && undo && (count_q != 4'd0);

    // Push the pre-commit bank counts on every accepted crossing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
        end else if (push) begin
            hist_q[HistAw'(count_q)] <= {m_q, c_q};
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = undo | (HIST_DEPTH == 0);
`endif

    // Next-state: start reinitialises outside RUN, step_en commits or errors inside RUN.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        c_d     = c_q;
        count_d = count_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle, StErr: begin
                if (start) begin
                    state_d = StRun;
                    m_d     = 2'd3;
                    c_d     = 2'd3;
                    count_d = 4'd0;
                end
            end
            StRun: begin
                if (step_en) begin
                    // Limit check comes first so step_count can never wrap.
                    if (at_limit || !safe || !move_ok) begin
                        state_d = StErr;
                    end else begin
                        m_d     = missionary_next;
                        c_d     = cannibal_next;
                        count_d = count_q + 4'd1;
                        push    = 1'b1;
                        if (missionary_next == 2'd0 && cannibal_next == 2'd0) state_d = StDone;
                    end
                end
`ifdef MC_UNDO_EN
                else if (pop_ok) begin
                    {m_d, c_d} = hist_top;
                    count_d    = count_q - 4'd1;
                end
`endif
            end
            StDone: begin
                if (start) begin
                    state_d = StRun;
                    m_d     = 2'd3;
                    c_d     = 2'd3;
                    count_d = 4'd0;
                end
`ifdef MC_UNDO_EN
                else if (pop_ok) begin
                    state_d    = StRun;
                    {m_d, c_d} = hist_top;
                    count_d    = count_q - 4'd1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; flags are registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            m_q     <= 2'd3;
            c_q     <= 2'd3;
            count_q <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            c_q     <= c_d;
            count_q <= count_d;
            busy_q  <= (state_d == StRun);
            done_q  <= (state_d == StDone);
            error_q <= (state_d == StErr);
        end
    end

    assign missionary_curr = m_q;
    assign cannibal_curr   = c_q;
    assign step_count      = count_q;
    // Boat side is implied by crossing parity.
    assign direction       = ~count_q[0];
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;

endmodule
